// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM state encoding and grant indices.
// Round-robin tie-break is enabled by defining SRAM_ARB_RR_EN.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  localparam logic GNT0 = 1'b0;
  localparam logic GNT1 = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select between two SRAM clients.
// SRAM_ARB_RR_EN: round-robin on ties; otherwise client 0 always wins a tie.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
`ifdef SRAM_ARB_RR_EN
  input  logic i_last,
`endif
  output logic o_gnt
);

  always_comb begin
    o_gnt = GNT0;
    unique case (1'b1)
      (i_req0 && i_req1): begin
`ifdef SRAM_ARB_RR_EN
        o_gnt = (i_last == GNT1) ? GNT0 : GNT1;
`else
        o_gnt = GNT0;
`endif
      end
      (i_req1 && !i_req0): o_gnt = GNT1;
      default:             o_gnt = GNT0;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-client arbiter and sequencer for a shared synchronous single-port SRAM.
// SRAM_ARB_RR_EN selects round-robin tie-break (default build: fixed priority).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sram_cs,
  output logic                  sram_wr,
  output logic                  sram_rd,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  state_t r_state, w_state_nxt;

  logic r_cs, r_wr, r_rd;
  logic r_ack0, r_ack1, r_rv0, r_rv1;
  logic w_cs, w_wr, w_rd;
  logic w_ack0, w_ack1, w_rv0, w_rv1;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_din, w_din;

  logic w_any, w_pick, w_we;

  assign w_any = req0 | req1;
  assign w_we  = (w_pick == GNT1) ? we1 : we0;

`ifdef SRAM_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_last <= GNT1;
    else if (r_state == IDLE && w_any)
      r_last <= w_pick;
  end
`endif

  sram_arb_pick u_pick (
    .i_req0 (req0),
    .i_req1 (req1),
`ifdef SRAM_ARB_RR_EN
    .i_last (r_last),
`endif
    .o_gnt  (w_pick)
  );

  // In ACCESS the ack and wr registers still identify winner and direction.
  always_comb begin
    w_state_nxt = r_state;
    w_cs   = 1'b0;
    w_wr   = 1'b0;
    w_rd   = 1'b0;
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    w_rv0  = 1'b0;
    w_rv1  = 1'b0;
    w_addr = r_addr;
    w_din  = r_din;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = ACCESS;
          w_cs   = 1'b1;
          w_wr   = w_we;
          w_rd   = ~w_we;
          w_ack0 = (w_pick == GNT0);
          w_ack1 = (w_pick == GNT1);
          w_addr = (w_pick == GNT1) ? addr1 : addr0;
          w_din  = (w_pick == GNT1) ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        if (r_wr) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RDATA;
          w_rv0 = r_ack0;
          w_rv1 = r_ack1;
        end
      end
      RDATA:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cs    <= w_cs;
      r_wr    <= w_wr;
      r_rd    <= w_rd;
      r_ack0  <= w_ack0;
      r_ack1  <= w_ack1;
      r_rv0   <= w_rv0;
      r_rv1   <= w_rv1;
      r_addr  <= w_addr;
      r_din   <= w_din;
    end
  end

  assign sram_cs   = r_cs;
  assign sram_wr   = r_wr;
  assign sram_rd   = r_rd;
  assign sram_addr = r_addr;
  assign sram_din  = r_din;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rvalid0   = r_rv0;
  assign rvalid1   = r_rv1;
  assign rdata     = sram_dout;

endmodule
